wb_retire_unit: RTL and testbench
=================================

# wb_retire_unit

Parametrised write-back and retire stage for the LoongArch pipeline.
- Accepts an in-order bundle of up to `LANES` instructions from MEM and commits register writes.
- Resolves precise exceptions and `ertn` with lane-ordered priority, drives the CSR file, and emits per-lane trace.
- Adds a configurable CSR read latency with a stall counter, and squashes same-bundle write-after-write (WAW) collisions.
- Sits between MEM and the register file/CSR unit; its exception and `ertn` outputs are the pipeline-wide flush source.

## Interface
Parameters:
- `LANES`, 2, retire lanes per bundle (1..4); lane 0 is oldest.
- `CSR_RD_LAT`, 0, extra cycles before `csr_rvalue` is valid (0..7).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `wb_allowin`  out  1  stage can accept a bundle this cycle.
- `mem_wb_valid`  in  1  bundle present.
- `mem_lane_valid`  in  LANES  per-lane occupancy; a lane may be empty.
- `mem_pc`  in  32*LANES  lane PCs.
- `mem_rf_we`  in  LANES  lane register-write enables.
- `mem_rf_waddr`  in  5*LANES  lane destination registers.
- `mem_rf_wdata`  in  32*LANES  lane write data.
- `mem_vaddr`  in  32*LANES  lane bad-address candidates.
- `mem_exc`  in  6*LANES  per lane, in order {ale, adef, ine, int, brk, sys}.
- `mem_ertn`  in  LANES  lane is `ertn`.
- `mem_csr_bus`  in  80  lane 0 only: {csr_re, csr_we, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0]}.
- `csr_rvalue`  in  32  CSR read data.
- `csr_num`  out  14, `csr_we`  out  1, `csr_wmask`  out  32, `csr_wvalue`  out  32  CSR access.
- `exc_signal`  out  1, `ertn_signal`  out  1  flush pulses.
- `wb_ecode`  out  6, `wb_esubcode`  out  9, `wb_pc`  out  32, `wb_vaddr`  out  32  exception info of the faulting lane.
- `rf_we`  out  LANES, `rf_waddr`  out  5*LANES, `rf_wdata`  out  32*LANES  register-file write ports.
- `debug_wb_pc`  out  32*LANES, `debug_wb_rf_we`  out  4*LANES, `debug_wb_rf_wnum`  out  5*LANES, `debug_wb_rf_wdata`  out  32*LANES  trace.

## Operation
- States: EMPTY (valid=0), WAIT (bundle held, counter < CSR_RD_LAT), RETIRE (bundle held, ready_go=1).
- Accept: `mem_wb_valid & wb_allowin` captures every `mem_*` field.
  - Next state is WAIT if lane 0 is valid with csr_re, CSR_RD_LAT>0, and the bundle carries no exception.
  - Otherwise next state is RETIRE.
- The counter resets to 0 on accept and increments in WAIT. WAIT moves to RETIRE when the counter reaches CSR_RD_LAT.
- Rule: `wb_allowin = ~valid | ready_go`.
- Fault lane f: the lowest valid lane with any `mem_exc` bit or `mem_ertn`.
  - Lanes < f commit.
  - Lane f and every lane above it are suppressed. An `ertn` lane itself makes no register write.
- ecode priority within lane f: INT > ADEF > ALE > SYS > BRK > INE, using package constants. `wb_esubcode`=0.
- Exception outputs: `wb_pc` = pc[f]; `wb_vaddr` = vaddr[f].
- `exc_signal` / `ertn_signal` go high only in RETIRE and last one cycle.
- WAW: among committing lanes that write the same `rf_waddr`, only the highest lane keeps `rf_we`. Writes to r0 are passed through unchanged.
- Lane 0 `rf_wdata` = `csr_rvalue` when csr_re is set, else the latched data.
- `csr_we` is high only in RETIRE, only when lane 0 commits (f>0). `csr_num`/`csr_wmask`/`csr_wvalue` are 0 when the stage is not valid.
- `rf_we` and `debug_wb_rf_we` (4 bits per lane, replicated) are high only in RETIRE.
- Flush: if `exc_signal|ertn_signal` is high, valid←0 at the next edge. Any bundle offered in that cycle is dropped.

## Timing
- Latency is 1 cycle from capture edge to retire with CSR_RD_LAT=0; a CSR read takes 1+CSR_RD_LAT cycles.
- Commit pulses last exactly one cycle per bundle. Back-to-back bundles give full throughput.
- Reset values: valid=0, counter=0, latched fields=0, every output 0.
- A reset asserted mid-WAIT aborts the bundle with no commit and no CSR write.
- Simultaneous flush and `mem_wb_valid`: the flush wins.
- An all-lanes-empty bundle retires with no writes.

## Structure
- Package `wb_pkg`: ECODE_* constants, exception-vector bit indices, `csr_bus_t` field widths.
- Sub-module `wb_fault_arbiter`: combinational first-fault finder, ecode encoder, and commit mask.

## Test plan
- LANES=2, lane0 r4←0x11, lane1 r5←0x22 → one cycle later rf_we=2'b11, debug PCs match.
- Lane0 and lane1 both write r7 (0xA, 0xB) → rf_we=2'b10, r7=0xB.
- Lane1 ALE with vaddr 0x1003, lane0 valid → lane0 commits, exc_signal=1, ecode=ALE (0x09), wb_pc=pc1, wb_vaddr=0x1003; the following bundle is dropped.
- CSR_RD_LAT=3, lane0 csrrd r6 → wb_allowin=0 for 3 cycles, then rf_we[0]=1 with r6=csr_rvalue.
- Lane0 with INT+ADEF → ecode=INT (0x00), no rf_we, no csr_we.
- Reset pulse in WAIT → all outputs 0 next cycle, no commit after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants, exception-vector layout and types for the write-back /
// retire stage.
package wb_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Per-lane exception vector, packed as {ale, adef, ine, int, brk, sys}
    localparam int EXC_W    = 6;
    localparam int EXC_SYS  = 0;
    localparam int EXC_BRK  = 1;
    localparam int EXC_INT  = 2;
    localparam int EXC_INE  = 3;
    localparam int EXC_ADEF = 4;
    localparam int EXC_ALE  = 5;

    localparam int CSR_NUM_W  = 14;
    localparam int CSR_DATA_W = 32;
    localparam int CSR_BUS_W  = 2 + CSR_NUM_W + 2 * CSR_DATA_W;

    typedef struct packed {
        logic                  re;
        logic                  we;
        logic [CSR_NUM_W-1:0]  num;
        logic [CSR_DATA_W-1:0] wmask;
        logic [CSR_DATA_W-1:0] wvalue;
    } csr_bus_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RETIRE = 2'd2
    } wb_state_e;

    // Highest-priority cause wins: INT > ADEF > ALE > SYS > BRK > INE
    function automatic logic [5:0] encode_ecode(input logic [EXC_W-1:0] exc);
        if (exc[EXC_INT])       return ECODE_INT;
        else if (exc[EXC_ADEF]) return ECODE_ADEF;
        else if (exc[EXC_ALE])  return ECODE_ALE;
        else if (exc[EXC_SYS])  return ECODE_SYS;
        else if (exc[EXC_BRK])  return ECODE_BRK;
        else                    return ECODE_INE;
    endfunction

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM -> WB bundle, CSR access, flush and register-file/trace signals of the
// retire stage. master = the driving side (MEM/CSR/regfile), slave = WB stage.
interface wb_retire_unit_if import wb_pkg::*; #(parameter int LANES = 2);
    logic                  wb_allowin;
    logic                  mem_wb_valid;
    logic [LANES-1:0]      mem_lane_valid;
    logic [32*LANES-1:0]   mem_pc;
    logic [LANES-1:0]      mem_rf_we;
    logic [5*LANES-1:0]    mem_rf_waddr;
    logic [32*LANES-1:0]   mem_rf_wdata;
    logic [32*LANES-1:0]   mem_vaddr;
    logic [6*LANES-1:0]    mem_exc;
    logic [LANES-1:0]      mem_ertn;
    logic [CSR_BUS_W-1:0]  mem_csr_bus;
    logic [31:0]           csr_rvalue;
    logic [13:0]           csr_num;
    logic                  csr_we;
    logic [31:0]           csr_wmask;
    logic [31:0]           csr_wvalue;
    logic                  exc_signal;
    logic                  ertn_signal;
    logic [5:0]            wb_ecode;
    logic [8:0]            wb_esubcode;
    logic [31:0]           wb_pc;
    logic [31:0]           wb_vaddr;
    logic [LANES-1:0]      rf_we;
    logic [5*LANES-1:0]    rf_waddr;
    logic [32*LANES-1:0]   rf_wdata;
    logic [32*LANES-1:0]   debug_wb_pc;
    logic [4*LANES-1:0]    debug_wb_rf_we;
    logic [5*LANES-1:0]    debug_wb_rf_wnum;
    logic [32*LANES-1:0]   debug_wb_rf_wdata;

    modport master (
        input  wb_allowin, csr_num, csr_we, csr_wmask, csr_wvalue,
               exc_signal, ertn_signal, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
               rf_we, rf_waddr, rf_wdata,
               debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output mem_wb_valid, mem_lane_valid, mem_pc, mem_rf_we, mem_rf_waddr,
               mem_rf_wdata, mem_vaddr, mem_exc, mem_ertn, mem_csr_bus, csr_rvalue
    );

    modport slave (
        output wb_allowin, csr_num, csr_we, csr_wmask, csr_wvalue,
               exc_signal, ertn_signal, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
               rf_we, rf_waddr, rf_wdata,
               debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  mem_wb_valid, mem_lane_valid, mem_pc, mem_rf_we, mem_rf_waddr,
               mem_rf_wdata, mem_vaddr, mem_exc, mem_ertn, mem_csr_bus, csr_rvalue
    );
endinterface

// File: rtl/wb_fault_arbiter.sv
// Combinational first-fault finder: locates the oldest valid lane carrying an
// exception or ertn, encodes its ecode and marks the older lanes as committing.
module wb_fault_arbiter import wb_pkg::*; #(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]       lane_valid,
    input  logic [EXC_W*LANES-1:0] exc,
    input  logic [LANES-1:0]       ertn,
    output logic                   fault_exc,
    output logic                   fault_ertn,
    output logic [1:0]             fault_lane,
    output logic [5:0]             ecode,
    output logic [LANES-1:0]       commit
);
    logic             blocked;
    logic [EXC_W-1:0] lane_exc;

    // Walk lanes oldest-first; the first faulting lane blocks itself and all younger lanes
    always_comb begin
        blocked    = 1'b0;
        lane_exc   = '0;
        fault_exc  = 1'b0;
        fault_ertn = 1'b0;
        fault_lane = '0;
        ecode      = '0;
        commit     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_exc = exc[EXC_W*i +: EXC_W];
            if (lane_valid[i] && !blocked) begin
                if ((|lane_exc) || ertn[i]) begin
                    blocked    = 1'b1;
                    fault_lane = 2'(i);
                    fault_exc  = |lane_exc;
                    fault_ertn = ~(|lane_exc) & ertn[i];
                    if (|lane_exc) begin
                        ecode = encode_ecode(lane_exc);
                    end
                end else begin
                    commit[i] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/wb_retire_unit.sv
// Write-back / retire stage: holds one MEM bundle, optionally waits for a slow
// CSR read, then commits register writes, CSR writes and raises flush pulses.
module wb_retire_unit import wb_pkg::*; #(
    parameter int LANES      = 2,
    parameter int CSR_RD_LAT = 0
) (
    input  logic           clk,
    input  logic           reset,
    wb_retire_unit_if.slave bus
);
    localparam logic [2:0] LAT_LAST = 3'(CSR_RD_LAT - 1);

    wb_state_e             state;
    logic [2:0]            cnt;
    logic [LANES-1:0]      lane_valid_q;
    logic [32*LANES-1:0]   pc_q;
    logic [LANES-1:0]      rf_we_q;
    logic [5*LANES-1:0]    waddr_q;
    logic [32*LANES-1:0]   wdata_q;
    logic [32*LANES-1:0]   vaddr_q;
    logic [6*LANES-1:0]    exc_q;
    logic [LANES-1:0]      ertn_q;
    csr_bus_t              csr_q;

    csr_bus_t              csr_in;
    logic                  in_exc;
    logic                  go_wait;
    logic                  valid;
    logic                  retire;
    logic                  flush;
    logic                  accept;
    logic                  fault_exc;
    logic                  fault_ertn;
    logic [1:0]            fault_lane;
    logic [5:0]            ecode;
    logic [LANES-1:0]      commit;
    logic [LANES-1:0]      we_keep;
    logic [32*LANES-1:0]   wdata_out;

    wb_fault_arbiter #(.LANES(LANES)) u_arb (
        .lane_valid (lane_valid_q),
        .exc        (exc_q),
        .ertn       (ertn_q),
        .fault_exc  (fault_exc),
        .fault_ertn (fault_ertn),
        .fault_lane (fault_lane),
        .ecode      (ecode),
        .commit     (commit)
    );

    assign csr_in          = csr_bus_t'(bus.mem_csr_bus);
    assign valid           = (state != ST_EMPTY);
    assign retire          = (state == ST_RETIRE);
    assign bus.wb_allowin  = ~valid | retire;
    assign bus.exc_signal  = retire & fault_exc;
    assign bus.ertn_signal = retire & fault_ertn;
    assign flush           = bus.exc_signal | bus.ertn_signal;
    assign accept          = bus.mem_wb_valid & bus.wb_allowin & ~flush;
    assign go_wait         = bus.mem_lane_valid[0] & csr_in.re & (CSR_RD_LAT != 0) & ~in_exc;

    // Incoming bundle carries an exception on any occupied lane
    always_comb begin
        in_exc = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.mem_lane_valid[i] && (|bus.mem_exc[6*i +: 6])) begin
                in_exc = 1'b1;
            end
        end
    end

    // Stage FSM, CSR-latency counter and bundle capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_EMPTY;
            cnt          <= '0;
            lane_valid_q <= '0;
            pc_q         <= '0;
            rf_we_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            vaddr_q      <= '0;
            exc_q        <= '0;
            ertn_q       <= '0;
            csr_q        <= '0;
        end else if (accept) begin
            state        <= go_wait ? ST_WAIT : ST_RETIRE;
            cnt          <= '0;
            lane_valid_q <= bus.mem_lane_valid;
            pc_q         <= bus.mem_pc;
            rf_we_q      <= bus.mem_rf_we;
            waddr_q      <= bus.mem_rf_waddr;
            wdata_q      <= bus.mem_rf_wdata;
            vaddr_q      <= bus.mem_vaddr;
            exc_q        <= bus.mem_exc;
            ertn_q       <= bus.mem_ertn;
            csr_q        <= csr_in;
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAT_LAST) begin
                        state <= ST_RETIRE;
                    end
                end
                ST_RETIRE: state <= ST_EMPTY;
                default:   state <= ST_EMPTY;
            endcase
        end
    end

    // Same-bundle WAW squash: an older write loses to a younger committing write of the same register (r0 exempt)
    always_comb begin
        we_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (commit[i] && rf_we_q[i]) begin
                we_keep[i] = 1'b1;
                for (int j = 0; j < LANES; j++) begin
                    if ((j > i) && commit[j] && rf_we_q[j] && (waddr_q[5*i +: 5] != 5'd0) &&
                        (waddr_q[5*j +: 5] == waddr_q[5*i +: 5])) begin
                        we_keep[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Lane 0 returns CSR read data in place of its latched result
    always_comb begin
        wdata_out = wdata_q;
        if (csr_q.re) begin
            wdata_out[31:0] = bus.csr_rvalue;
        end
    end

    // Register-file, trace, CSR and exception-info outputs
    always_comb begin
        bus.rf_we             = '0;
        bus.rf_waddr          = '0;
        bus.rf_wdata          = '0;
        bus.debug_wb_pc       = '0;
        bus.debug_wb_rf_we    = '0;
        bus.debug_wb_rf_wnum  = '0;
        bus.debug_wb_rf_wdata = '0;
        if (retire) begin
            bus.rf_we             = we_keep;
            bus.rf_waddr          = waddr_q;
            bus.rf_wdata          = wdata_out;
            bus.debug_wb_pc       = pc_q;
            bus.debug_wb_rf_wnum  = waddr_q;
            bus.debug_wb_rf_wdata = wdata_out;
            for (int i = 0; i < LANES; i++) begin
                bus.debug_wb_rf_we[4*i +: 4] = {4{we_keep[i]}};
            end
        end
        bus.csr_we      = retire & commit[0] & csr_q.we;
        bus.csr_num     = valid ? csr_q.num    : '0;
        bus.csr_wmask   = valid ? csr_q.wmask  : '0;
        bus.csr_wvalue  = valid ? csr_q.wvalue : '0;
        bus.wb_ecode    = bus.exc_signal ? ecode : '0;
        bus.wb_esubcode = '0;
        bus.wb_pc       = flush ? pc_q[32*fault_lane +: 32]    : '0;
        bus.wb_vaddr    = flush ? vaddr_q[32*fault_lane +: 32] : '0;
    end
endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit with LANES=2, CSR_RD_LAT=3.
module tb_wb_retire_unit;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    wb_retire_unit_if #(.LANES(2)) bus ();

    wb_retire_unit #(.LANES(2), .CSR_RD_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bundle();
        bus.mem_wb_valid   = 1'b0;
        bus.mem_lane_valid = '0;
        bus.mem_pc         = '0;
        bus.mem_rf_we      = '0;
        bus.mem_rf_waddr   = '0;
        bus.mem_rf_wdata   = '0;
        bus.mem_vaddr      = '0;
        bus.mem_exc        = '0;
        bus.mem_ertn       = '0;
        bus.mem_csr_bus    = '0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd,
                            input logic [5:0] exc, input logic ertn, input logic [31:0] va);
        bus.mem_lane_valid[i]       = 1'b1;
        bus.mem_pc[32*i +: 32]      = pc;
        bus.mem_rf_we[i]            = we;
        bus.mem_rf_waddr[5*i +: 5]  = wa;
        bus.mem_rf_wdata[32*i +: 32] = wd;
        bus.mem_exc[6*i +: 6]       = exc;
        bus.mem_ertn[i]             = ertn;
        bus.mem_vaddr[32*i +: 32]   = va;
    endtask

    initial begin
        reset = 1'b1;
        bus.csr_rvalue = 32'h1234_5678;
        clear_bundle();
        step();
        step();
        chk("rst_allowin", 64'(bus.wb_allowin), 64'd1);
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_exc", 64'(bus.exc_signal), 64'd0);
        chk("rst_csr_num", 64'(bus.csr_num), 64'd0);
        chk("rst_dbg_pc", 64'(bus.debug_wb_pc), 64'd0);
        reset = 1'b0;

        // Two independent writes
        set_lane(0, 32'h1c00_0000, 1'b1, 5'd4, 32'h11, 6'b0, 1'b0, 32'h0);
        set_lane(1, 32'h1c00_0004, 1'b1, 5'd5, 32'h22, 6'b0, 1'b0, 32'h0);
        bus.mem_wb_valid = 1'b1;
        step();
        chk("t1_rf_we", 64'(bus.rf_we), 64'h3);
        chk("t1_waddr", 64'(bus.rf_waddr), 64'({5'd5, 5'd4}));
        chk("t1_wdata", 64'(bus.rf_wdata), {32'h22, 32'h11});
        chk("t1_dbg_pc", 64'(bus.debug_wb_pc), {32'h1c00_0004, 32'h1c00_0000});
        chk("t1_dbg_we", 64'(bus.debug_wb_rf_we), 64'hFF);

        // Back-to-back: WAW on r7
        clear_bundle();
        set_lane(0, 32'h1c00_0008, 1'b1, 5'd7, 32'hA, 6'b0, 1'b0, 32'h0);
        set_lane(1, 32'h1c00_000c, 1'b1, 5'd7, 32'hB, 6'b0, 1'b0, 32'h0);
        bus.mem_wb_valid = 1'b1;
        step();
        chk("t2_rf_we", 64'(bus.rf_we), 64'h2);
        chk("t2_wdata1", 64'(bus.rf_wdata[63:32]), 64'hB);
        chk("t2_waddr1", 64'(bus.rf_waddr[9:5]), 64'd7);
        chk("t2_dbg_we", 64'(bus.debug_wb_rf_we), 64'hF0);
        clear_bundle();
        step();
        chk("t2_pulse_end", 64'(bus.rf_we), 64'h0);

        // r0 writes are not squashed
        set_lane(0, 32'h1c00_0010, 1'b1, 5'd0, 32'h1, 6'b0, 1'b0, 32'h0);
        set_lane(1, 32'h1c00_0014, 1'b1, 5'd0, 32'h2, 6'b0, 1'b0, 32'h0);
        bus.mem_wb_valid = 1'b1;
        step();
        chk("r0_rf_we", 64'(bus.rf_we), 64'h3);
        clear_bundle();
        step();

        // Lane 1 ALE; next bundle offered during flush is dropped
        set_lane(0, 32'h1c00_0100, 1'b1, 5'd8, 32'h33, 6'b0, 1'b0, 32'h0);
        set_lane(1, 32'h1c00_0104, 1'b1, 5'd9, 32'h44, 6'b100000, 1'b0, 32'h1003);
        bus.mem_wb_valid = 1'b1;
        step();
        chk("ale_rf_we", 64'(bus.rf_we), 64'h1);
        chk("ale_exc", 64'(bus.exc_signal), 64'd1);
        chk("ale_ertn", 64'(bus.ertn_signal), 64'd0);
        chk("ale_ecode", 64'(bus.wb_ecode), 64'h09);
        chk("ale_esub", 64'(bus.wb_esubcode), 64'h0);
        chk("ale_pc", 64'(bus.wb_pc), 64'h1c00_0104);
        chk("ale_vaddr", 64'(bus.wb_vaddr), 64'h1003);
        clear_bundle();
        set_lane(0, 32'h1c00_0108, 1'b1, 5'd10, 32'h55, 6'b0, 1'b0, 32'h0);
        bus.mem_wb_valid = 1'b1;
        step();
        chk("drop_rf_we", 64'(bus.rf_we), 64'h0);
        chk("drop_exc", 64'(bus.exc_signal), 64'd0);
        chk("drop_allowin", 64'(bus.wb_allowin), 64'd1);
        clear_bundle();
        step();
        chk("drop_rf_we2", 64'(bus.rf_we), 64'h0);

        // ertn in lane 0
        set_lane(0, 32'h1c00_0200, 1'b1, 5'd11, 32'h66, 6'b0, 1'b1, 32'h0);
        set_lane(1, 32'h1c00_0204, 1'b1, 5'd12, 32'h77, 6'b0, 1'b0, 32'h0);
        bus.mem_wb_valid = 1'b1;
        step();
        chk("ertn_sig", 64'(bus.ertn_signal), 64'd1);
        chk("ertn_exc", 64'(bus.exc_signal), 64'd0);
        chk("ertn_rf_we", 64'(bus.rf_we), 64'h0);
        clear_bundle();
        step();

        // Lane 0 INT + ADEF with a pending CSR write
        set_lane(0, 32'h1c00_0300, 1'b1, 5'd13, 32'h88, 6'b010100, 1'b0, 32'h0);
        set_lane(1, 32'h1c00_0304, 1'b1, 5'd14, 32'h99, 6'b0, 1'b0, 32'h0);
        bus.mem_csr_bus  = {1'b0, 1'b1, 14'h007, 32'hFFFF_FFFF, 32'h5};
        bus.mem_wb_valid = 1'b1;
        step();
        chk("int_exc", 64'(bus.exc_signal), 64'd1);
        chk("int_ecode", 64'(bus.wb_ecode), 64'h00);
        chk("int_rf_we", 64'(bus.rf_we), 64'h0);
        chk("int_csr_we", 64'(bus.csr_we), 64'd0);
        chk("int_pc", 64'(bus.wb_pc), 64'h1c00_0300);
        clear_bundle();
        step();

        // CSR write commits from lane 0
        set_lane(0, 32'h1c00_0400, 1'b0, 5'd0, 32'h0, 6'b0, 1'b0, 32'h0);
        bus.mem_csr_bus  = {1'b0, 1'b1, 14'h006, 32'hFFFF_FFFF, 32'h0000_0ABC};
        bus.mem_wb_valid = 1'b1;
        step();
        chk("csrw_we", 64'(bus.csr_we), 64'd1);
        chk("csrw_num", 64'(bus.csr_num), 64'h006);
        chk("csrw_wvalue", 64'(bus.csr_wvalue), 64'hABC);
        chk("csrw_wmask", 64'(bus.csr_wmask), 64'hFFFF_FFFF);
        clear_bundle();
        step();
        chk("csrw_idle_we", 64'(bus.csr_we), 64'd0);
        chk("csrw_idle_num", 64'(bus.csr_num), 64'h0);

        // CSR read with 3 extra cycles of latency
        set_lane(0, 32'h1c00_0500, 1'b1, 5'd6, 32'hDEAD, 6'b0, 1'b0, 32'h0);
        bus.mem_csr_bus  = {1'b1, 1'b0, 14'h005, 32'h0, 32'h0};
        bus.mem_wb_valid = 1'b1;
        step();
        clear_bundle();
        chk("csrr_allow0", 64'(bus.wb_allowin), 64'd0);
        chk("csrr_we0", 64'(bus.rf_we), 64'h0);
        chk("csrr_num", 64'(bus.csr_num), 64'h005);
        step();
        chk("csrr_allow1", 64'(bus.wb_allowin), 64'd0);
        step();
        chk("csrr_allow2", 64'(bus.wb_allowin), 64'd0);
        step();
        chk("csrr_allow3", 64'(bus.wb_allowin), 64'd1);
        chk("csrr_rf_we", 64'(bus.rf_we), 64'h1);
        chk("csrr_waddr", 64'(bus.rf_waddr[4:0]), 64'd6);
        chk("csrr_wdata", 64'(bus.rf_wdata[31:0]), 64'h1234_5678);
        step();
        chk("csrr_end", 64'(bus.rf_we), 64'h0);

        // All-lanes-empty bundle
        bus.mem_wb_valid = 1'b1;
        step();
        clear_bundle();
        chk("empty_rf_we", 64'(bus.rf_we), 64'h0);
        chk("empty_exc", 64'(bus.exc_signal), 64'd0);
        chk("empty_dbg_we", 64'(bus.debug_wb_rf_we), 64'h0);
        step();

        // Reset while waiting on a CSR read aborts the bundle
        set_lane(0, 32'h1c00_0600, 1'b1, 5'd6, 32'hBEEF, 6'b0, 1'b0, 32'h0);
        bus.mem_csr_bus  = {1'b1, 1'b1, 14'h009, 32'hFFFF_FFFF, 32'h1};
        bus.mem_wb_valid = 1'b1;
        step();
        clear_bundle();
        chk("rw_wait", 64'(bus.wb_allowin), 64'd0);
        reset = 1'b1;
        #1;
        chk("rw_async_allow", 64'(bus.wb_allowin), 64'd1);
        step();
        chk("rw_csr_num", 64'(bus.csr_num), 64'h0);
        chk("rw_rf_we", 64'(bus.rf_we), 64'h0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rw_no_commit", 64'({bus.csr_we, bus.rf_we}), 64'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
